fir_stream_sequencer: RTL and testbench

Controller that drives one run of the FIR filter IP (Avalon-ST sink/source, 16-bit samples) from a sample memory and stores every filter output in a result memory. On `start` it streams NUM_SAMPLES input samples into the filter, appends NUM_TAPS-1 zero samples to flush the delay line, then captures the full-length convolution (NUM_SAMPLES+NUM_TAPS-1 outputs). It sits between the input sample RAM, the FIR IP instance and the result RAM, and replaces testbench-driven stimulus in the synthesised design.

---
 rtl/fir_seq_pkg.sv | 25 ++
 rtl/fir_seq_counter.sv | 32 +++
 rtl/fir_stream_sequencer.sv | 138 +++++++++++++
 tb/tb_fir_stream_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_seq_pkg.sv
// fir_seq_pkg: shared definitions for the FIR stream sequencer.
//   - state encoding of the run FSM
//   - total_out(): full convolution length for a given sample/tap count
package fir_seq_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FEED  = 3'd1;
  localparam logic [2:0] ST_FLUSH = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_FEED  = ST_FEED,
    S_FLUSH = ST_FLUSH,
    S_DRAIN = ST_DRAIN,
    S_DONE  = ST_DONE
  } state_t;

  // Outputs of a full-length convolution.
  function automatic int total_out(input int num_samples, input int num_taps);
    return num_samples + num_taps - 1;
  endfunction

endpackage

// File: rtl/fir_seq_counter.sv
// fir_seq_counter: loadable up-counter with synchronous clear.
//   clk, rst     : clock, synchronous active-high reset
//   clr          : synchronous clear to 0 (wins over load/en)
//   load/load_val: synchronous load
//   en           : count enable
//   q            : current count
//   tc           : terminal-count flag, q == LAST
module fir_seq_counter #(
  parameter int W    = 8,
  parameter int LAST = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         tc
);

  localparam logic [W-1:0] LAST_V = W'(LAST);

  always_ff @(posedge clk) begin
    if (rst || clr)  q <= '0;
    else if (load)   q <= load_val;
    else if (en)     q <= q + 1'b1;
  end

  assign tc = (q == LAST_V);

endmodule

// File: rtl/fir_stream_sequencer.sv
// fir_stream_sequencer: drives one FIR run from the sample RAM and stores
// every filter output in the result RAM.
//   start            : one-cycle run request (IDLE only)
//   busy/done        : run in progress / one-cycle completion pulse
//   timeout          : sticky, last run gave up waiting for outputs
//   in_rd_*          : input RAM read port; in_rd_data is taken at the
//                      clock edge closing the cycle the address is shown
//   fir_sink_*       : Avalon-ST beats to the filter (never back-pressured)
//   fir_source_*     : Avalon-ST beats from the filter
//   out_wr_*         : result RAM write port (registered)
//   out_count        : outputs captured in the current/last run
module fir_stream_sequencer
  import fir_seq_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int NUM_SAMPLES   = 2400,
  parameter int NUM_TAPS      = 123,
  parameter int IN_ADDR_W     = 12,
  parameter int OUT_ADDR_W    = 12,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic                  in_rd_en,
  output logic [IN_ADDR_W-1:0]  in_rd_addr,
  input  logic [DATA_W-1:0]     in_rd_data,
  output logic [DATA_W-1:0]     fir_sink_data,
  output logic                  fir_sink_valid,
  input  logic [DATA_W-1:0]     fir_source_data,
  input  logic                  fir_source_valid,
  output logic                  out_wr_en,
  output logic [OUT_ADDR_W-1:0] out_wr_addr,
  output logic [DATA_W-1:0]     out_wr_data,
  output logic [OUT_ADDR_W-1:0] out_count
);

  localparam int TOTAL = total_out(NUM_SAMPLES, NUM_TAPS);
  localparam int FW    = $clog2(NUM_TAPS + 1);
  localparam int TW    = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [OUT_ADDR_W-1:0] TOTAL_V = OUT_ADDR_W'(TOTAL);

  state_t          state;
  logic            start_acc, active, cap, complete_now;
  logic            feed_last, flush_last, cnt_last, idle_last;
  logic [FW-1:0]   flush_q_unused;
  logic [TW-1:0]   idle_q_unused;

  assign start_acc = (state == S_IDLE) && start;
  assign active    = (state == S_FEED) || (state == S_FLUSH) || (state == S_DRAIN);
  // Capture stops at the full convolution length; surplus outputs are dropped.
  assign cap       = active && fir_source_valid && (out_count != TOTAL_V);
  // Include this cycle's capture so the last output ends DRAIN right away
  // and beats a timeout landing on the same cycle.
  assign complete_now = (out_count == TOTAL_V) || (cap && cnt_last);

  // Feed index doubles as the registered input RAM address.
  fir_seq_counter #(.W(IN_ADDR_W), .LAST(NUM_SAMPLES-1)) u_feed (
    .clk(clk), .rst(rst), .clr(start_acc), .load(1'b0), .load_val('0),
    .en((state == S_FEED) && !feed_last), .q(in_rd_addr), .tc(feed_last));

  fir_seq_counter #(.W(FW), .LAST(NUM_TAPS-2)) u_flush (
    .clk(clk), .rst(rst), .clr(start_acc), .load(1'b0), .load_val('0),
    .en((state == S_FLUSH) && !flush_last), .q(flush_q_unused), .tc(flush_last));

  fir_seq_counter #(.W(OUT_ADDR_W), .LAST(TOTAL-1)) u_out (
    .clk(clk), .rst(rst), .clr(start_acc), .load(1'b0), .load_val('0),
    .en(cap), .q(out_count), .tc(cnt_last));

  // Consecutive DRAIN cycles without a filter output; tc marks the cycle
  // that would make DRAIN_TIMEOUT of them.
  fir_seq_counter #(.W(TW), .LAST(DRAIN_TIMEOUT-1)) u_idle (
    .clk(clk), .rst(rst), .clr(start_acc || fir_source_valid), .load(1'b0),
    .load_val('0), .en((state == S_DRAIN) && !fir_source_valid),
    .q(idle_q_unused), .tc(idle_last));

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      timeout        <= 1'b0;
      in_rd_en       <= 1'b0;
      fir_sink_valid <= 1'b0;
      fir_sink_data  <= '0;
      out_wr_en      <= 1'b0;
      out_wr_addr    <= '0;
      out_wr_data    <= '0;
    end else begin
      done           <= 1'b0;
      fir_sink_valid <= 1'b0;
      out_wr_en      <= cap;
      if (cap) begin
        out_wr_addr <= out_count;
        out_wr_data <= fir_source_data;
      end
      case (state)
        S_IDLE: if (start) begin
          state    <= S_FEED;
          busy     <= 1'b1;
          in_rd_en <= 1'b1;
          timeout  <= 1'b0;
        end
        S_FEED: begin
          fir_sink_valid <= 1'b1;
          fir_sink_data  <= in_rd_data;
          if (feed_last) begin
            in_rd_en <= 1'b0;
            state    <= (NUM_TAPS > 1) ? S_FLUSH : S_DRAIN;
          end
        end
        S_FLUSH: begin
          fir_sink_valid <= 1'b1;
          fir_sink_data  <= '0;
          if (flush_last) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (complete_now) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (!fir_source_valid && idle_last) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_stream_sequencer.sv
// Bench for fir_stream_sequencer with a small configuration and a stub
// filter that echoes sink beats 3 cycles later (optionally truncated or
// padded with extra outputs).
module tb_fir_stream_sequencer;

  localparam int NS = 8, NT = 4, DT = 16, DW = 16, IAW = 4, OAW = 4;
  localparam int TOT = NS + NT - 1;

  typedef struct {
    logic [OAW-1:0] a;
    logic [DW-1:0]  d;
  } wr_t;

  logic           clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic           busy, done, timeout, in_rd_en, fir_sink_valid, fir_source_valid, out_wr_en;
  logic [IAW-1:0] in_rd_addr;
  logic [DW-1:0]  in_rd_data, fir_sink_data, fir_source_data, out_wr_data;
  logic [OAW-1:0] out_wr_addr, out_count;

  fir_stream_sequencer #(
    .DATA_W(DW), .NUM_SAMPLES(NS), .NUM_TAPS(NT),
    .IN_ADDR_W(IAW), .OUT_ADDR_W(OAW), .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .timeout(timeout), .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr),
    .in_rd_data(in_rd_data), .fir_sink_data(fir_sink_data),
    .fir_sink_valid(fir_sink_valid), .fir_source_data(fir_source_data),
    .fir_source_valid(fir_source_valid), .out_wr_en(out_wr_en),
    .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data), .out_count(out_count)
  );

  always #5 clk = ~clk;

  int cyc = 0, t0 = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0, total = 0;

  // Input RAM: data for the address shown this cycle.
  logic [DW-1:0] ram [0:15];
  assign in_rd_data = ram[in_rd_addr];

  // Stub filter: 3-cycle identity delay, at most `limit` outputs; once the
  // echoed stream is exhausted it pads with 16'hBEEF up to `limit`.
  logic [2:0]    pv;
  logic [DW-1:0] pd [3];
  int            n_emit;
  int            limit = 0;
  logic          stub_clr = 1'b1;
  always @(posedge clk) begin
    if (stub_clr) begin
      pv     <= '0;
      n_emit <= 0;
    end else begin
      pv    <= {pv[1:0], fir_sink_valid};
      pd[0] <= fir_sink_data;
      pd[1] <= pd[0];
      pd[2] <= pd[1];
      if (fir_source_valid) n_emit <= n_emit + 1;
    end
  end
  assign fir_source_valid = (n_emit < limit) && (pv[2] || n_emit >= TOT);
  assign fir_source_data  = pv[2] ? pd[2] : 16'hBEEF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboards: expected sink beats and result writes.
  logic [DW-1:0] sq[$];
  wr_t           wq[$];
  int            beats = 0, first_b = -1, last_b = -1, dones = 0, done_rel = -1;

  always @(negedge clk) begin
    if (fir_sink_valid) begin
      if (beats == 0) first_b = cyc - t0;
      last_b = cyc - t0;
      beats++;
      total++;
      assert (sq.size() != 0) passed++;
      else $error("FAIL sink_extra: observed beat %0h expected none", fir_sink_data);
      if (sq.size() != 0) chk("sink_data", fir_sink_data, sq.pop_front());
    end
    if (out_wr_en) begin
      total++;
      assert (wq.size() != 0) passed++;
      else $error("FAIL wr_extra: observed write addr %0d expected none", out_wr_addr);
      if (wq.size() != 0) begin
        wr_t w;
        w = wq.pop_front();
        chk("wr_addr", out_wr_addr, w.a);
        chk("wr_data", out_wr_data, w.d);
      end
    end
    if (done) begin
      dones++;
      done_rel = cyc - t0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load RAM with base + stp*k and queue the first n_sink beats / n_wr writes.
  task automatic fill(input logic [DW-1:0] base, input logic [DW-1:0] stp,
                      input int n_sink, input int n_wr);
    wr_t w;
    sq.delete();
    wq.delete();
    for (int k = 0; k < 16; k++) ram[k] = base + stp * 16'(k);
    for (int j = 0; j < n_sink; j++) sq.push_back(j < NS ? ram[j] : 16'h0);
    for (int i = 0; i < n_wr; i++) begin
      w.a = OAW'(i);
      w.d = (i < NS) ? ram[i] : 16'h0;
      wq.push_back(w);
    end
  endtask

  // Clear the stub, then pulse start in cycle 0; returns in cycle 1.
  task automatic run_start(input int lim);
    limit    = lim;
    stub_clr = 1'b1;
    step();
    stub_clr = 1'b0;
    beats = 0; first_b = -1; last_b = -1; dones = 0; done_rel = -1;
    start = 1'b1;
    t0 = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ctl"}, {busy, done, timeout, in_rd_en, fir_sink_valid, out_wr_en}, 0);
    chk({tag, "_addr"}, {in_rd_addr, out_wr_addr, out_count}, 0);
    chk({tag, "_data"}, {fir_sink_data, out_wr_data}, 0);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) step();
    chk_reset_outs("reset");
    rst = 1'b0;
    step();

    // Basic run with starts during FEED and DONE
    fill(16'd1, 16'd1, TOT, TOT);
    run_start(TOT);                       // cycle 1
    chk("c1_busy", busy, 1);
    chk("c1_rd_en", in_rd_en, 1);
    chk("c1_rd_addr", in_rd_addr, 0);
    chk("c1_sink_valid", fir_sink_valid, 0);
    repeat (4) step();                    // cycle 5
    start = 1'b1;
    step();
    start = 1'b0;                         // cycle 6
    repeat (10) step();                   // cycle 16
    chk("r1_done", done, 1);
    chk("r1_busy", busy, 0);
    chk("r1_count", out_count, TOT);
    chk("r1_timeout", timeout, 0);
    start = 1'b1;                         // start during DONE
    step();
    start = 1'b0;                         // cycle 17
    chk("r1_done_width", done, 0);
    repeat (5) step();
    chk("r1_start_in_done", busy, 0);
    chk("r1_dones", dones, 1);
    chk("r1_done_rel", done_rel, 16);
    chk("r1_beats", beats, TOT);
    chk("r1_first_beat", first_b, 2);
    chk("r1_last_beat", last_b, NS + NT);
    chk("r1_sq_left", sq.size(), 0);
    chk("r1_wq_left", wq.size(), 0);

    // Stub stops after 6 outputs: DRAIN from cycle 12, 16 idle cycles
    fill(16'h1000, 16'h0123, TOT, 6);
    run_start(6);
    repeat (26) step();                   // cycle 27
    chk("r2_done_early", done, 0);
    chk("r2_busy_27", busy, 1);
    chk("r2_timeout_27", timeout, 0);
    step();                               // cycle 28
    chk("r2_done", done, 1);
    chk("r2_timeout", timeout, 1);
    chk("r2_busy", busy, 0);
    chk("r2_count", out_count, 6);
    step();
    chk("r2_timeout_sticky", timeout, 1);
    repeat (3) step();
    chk("r2_dones", dones, 1);
    chk("r2_beats", beats, TOT);
    chk("r2_wq_left", wq.size(), 0);

    // Reset during the second FLUSH cycle (cycle 10)
    fill(16'h8001, 16'h0101, NS + 1, 5);
    run_start(TOT);
    chk("r3_timeout_clr", timeout, 0);
    chk("r3_busy", busy, 1);
    repeat (9) step();                    // cycle 10
    chk("r3_flush_beat", fir_sink_valid, 1);
    rst = 1'b1;
    step();                               // cycle 11
    chk_reset_outs("r3_rst");
    rst = 1'b0;
    repeat (6) step();
    chk("r3_dones", dones, 0);
    chk("r3_beats", beats, NS + 1);
    chk("r3_sq_left", sq.size(), 0);
    chk("r3_wq_left", wq.size(), 0);

    // Full run after reset; stub emits 13 outputs, only 11 kept
    fill(16'hFFF0, 16'hFFFD, TOT, TOT);
    run_start(TOT + 2);
    repeat (15) step();                   // cycle 16
    chk("r4_done", done, 1);
    chk("r4_count", out_count, TOT);
    chk("r4_timeout", timeout, 0);
    repeat (6) step();
    chk("r4_dones", dones, 1);
    chk("r4_done_rel", done_rel, 16);
    chk("r4_count_hold", out_count, TOT);
    chk("r4_beats", beats, TOT);
    chk("r4_sq_left", sq.size(), 0);
    chk("r4_wq_left", wq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
